// File: rtl/clock_pkg.sv
// Shared encodings and limits for the clock/calendar chain, the set controller and segment_show.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_HOUR  = 3'd1,
    ST_SET_MIN   = 3'd2,
    ST_SET_DAY   = 3'd3,
    ST_SET_MONTH = 3'd4,
    ST_COMMIT    = 3'd5
  } state_e;

  localparam logic [2:0] FIELD_NONE   = 3'd0;
  localparam logic [2:0] FIELD_HOUR   = 3'd1;
  localparam logic [2:0] FIELD_MINUTE = 3'd2;
  localparam logic [2:0] FIELD_DAY    = 3'd3;
  localparam logic [2:0] FIELD_MONTH  = 3'd4;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINUTE_MAX = 6'd59;
  localparam logic [4:0] DAY_MAX    = 5'd30;
  localparam logic [3:0] MONTH_MAX  = 4'd11;

  // Observation bundle: FSM state plus the debounced key levels.
  typedef struct packed {
    state_e state;
    logic   mode_level;
    logic   inc_level;
  } dbg_t;

  // Increment with wrap; anything at or above max returns to 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
    return (value >= max) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchroniser, tick-sampled level filter and a press pulse on 0->1.
module key_debounce #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_SAMPLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      press <= 1'b0;
      if (tick) begin
        // cnt holds how many consecutive samples have disagreed with level
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_SAMPLES - 1)) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time/date setting controller: key conditioning, INC auto-repeat, edit FSM with shadow
// registers, edit timeout and field blink. Commit is a one-cycle load strobe.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_SAMPLES   = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_RATE   = 4,
  parameter int BLINK_TICKS   = 8,
  parameter int TIMEOUT_TICKS = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [4:0] cur_day,
  input  logic [3:0] cur_month,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_minute,
  output logic [4:0] load_day,
  output logic [3:0] load_month,
  output logic [2:0] edit_field,
  output logic       blink,
  output dbg_t       debug
);

  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic          mode_press, mode_level, inc_press, inc_level;
  logic          tick_d, rep_fire, inc_ev;
  logic [RW-1:0] rep_cnt;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;
  state_e        state;

  key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_mode (
    .clock(clock), .reset(reset), .tick(tick), .key(key_mode),
    .level(mode_level), .press(mode_press)
  );

  key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_inc (
    .clock(clock), .reset(reset), .tick(tick), .key(key_inc),
    .level(inc_level), .press(inc_press)
  );

  // tick_d lines up tick-driven work with the press pulses the debouncers register on tick.
  assign rep_fire = tick_d && inc_level && (rep_cnt == RW'(REPEAT_DELAY));
  assign inc_ev   = inc_press | rep_fire;

  assign debug.state      = state;
  assign debug.mode_level = mode_level;
  assign debug.inc_level  = inc_level;

  // rep_cnt = ticks held since the debounced rise; after a fire it rewinds one rate period.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_d  <= 1'b0;
      rep_cnt <= '0;
    end else begin
      tick_d <= tick;
      if (!inc_level) begin
        rep_cnt <= '0;
      end else if (tick_d) begin
        rep_cnt <= rep_fire ? RW'(REPEAT_DELAY - REPEAT_RATE + 1) : rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      run_en      <= 1'b1;
      load        <= 1'b0;
      load_hour   <= '0;
      load_minute <= '0;
      load_day    <= '0;
      load_month  <= '0;
      edit_field  <= FIELD_NONE;
      blink       <= 1'b0;
      idle_cnt    <= '0;
      blink_cnt   <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        ST_RUN: begin
          if (mode_press) begin
            load_hour   <= cur_hour;
            load_minute <= cur_minute;
            load_day    <= cur_day;
            load_month  <= cur_month;
            state       <= ST_SET_HOUR;
            run_en      <= 1'b0;
            edit_field  <= FIELD_HOUR;
            blink       <= 1'b0;
            blink_cnt   <= '0;
            idle_cnt    <= '0;
          end
        end
        ST_COMMIT: state <= ST_RUN;
        default: begin
          if (mode_press) begin
            idle_cnt  <= '0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            if (state == ST_SET_MONTH) begin
              state      <= ST_COMMIT;
              load       <= 1'b1;
              run_en     <= 1'b1;
              edit_field <= FIELD_NONE;
            end else begin
              state      <= state_e'(state + 3'd1);
              edit_field <= edit_field + 3'd1;
            end
          end else if (inc_ev) begin
            idle_cnt  <= '0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            case (state)
              ST_SET_HOUR:  load_hour   <= 5'(wrap_inc(6'(load_hour), 6'(HOUR_MAX)));
              ST_SET_MIN:   load_minute <= wrap_inc(load_minute, MINUTE_MAX);
              ST_SET_DAY:   load_day    <= 5'(wrap_inc(6'(load_day), 6'(DAY_MAX)));
              ST_SET_MONTH: load_month  <= 4'(wrap_inc(6'(load_month), 6'(MONTH_MAX)));
              default: ;
            endcase
          end else if (tick_d) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
              blink     <= ~blink;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            // Timeout placed after blink so its blink clear takes precedence.
            if (idle_cnt == IW'(TIMEOUT_TICKS - 1)) begin
              state      <= ST_RUN;
              run_en     <= 1'b1;
              edit_field <= FIELD_NONE;
              blink      <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
